// File: rtl/core_isa_pkg.sv
// rtl/core_isa_pkg.sv - opcode constants, opcode classes and fetch state encoding
package core_isa_pkg;

  localparam int OPCODE_W = 8;

  localparam logic [OPCODE_W-1:0] OP_EN0   = 8'd3;
  localparam logic [OPCODE_W-1:0] OP_EN1   = 8'd4;
  localparam logic [OPCODE_W-1:0] OP_EN2   = 8'd5;
  localparam logic [OPCODE_W-1:0] OP_EN3   = 8'd6;
  localparam logic [OPCODE_W-1:0] OP_ENALL = 8'd7;
  localparam logic [OPCODE_W-1:0] OP_END   = 8'd38;
  localparam logic [OPCODE_W-1:0] OP_JUMNZ = 8'd40;

  typedef enum logic [2:0] {
    CLS_EN_SELF,
    CLS_EN_OTHER,
    CLS_END,
    CLS_JUMP,
    CLS_DATAPATH
  } opclass_e;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t S_IDLE   = 3'd0;
  localparam fetch_state_t S_FETCH  = 3'd1;
  localparam fetch_state_t S_DECODE = 3'd2;
  localparam fetch_state_t S_ISSUE  = 3'd3;
  localparam fetch_state_t S_OPND   = 3'd4;
  localparam fetch_state_t S_HALT   = 3'd5;

endpackage

// File: rtl/core_opcode_classify.sv
// rtl/core_opcode_classify.sv - maps a fetched opcode to its control class for one core
module core_opcode_classify
  import core_isa_pkg::*;
#(
  parameter int CORE_ID = 0
) (
  input  logic [OPCODE_W-1:0] instr,
  output opclass_e            op_class
);

  localparam logic [OPCODE_W-1:0] OP_EN_SELF = 8'(OP_EN0 + CORE_ID);

  always_comb begin
    op_class = CLS_DATAPATH;
    if (instr == OP_EN_SELF || instr == OP_ENALL) begin
      op_class = CLS_EN_SELF;
    end else if (instr >= OP_EN0 && instr <= OP_EN3) begin
      op_class = CLS_EN_OTHER;
    end else if (instr == OP_END) begin
      op_class = CLS_END;
    end else if (instr == OP_JUMNZ) begin
      op_class = CLS_JUMP;
    end
  end

endmodule

// File: rtl/core_fetch_sequencer.sv
// rtl/core_fetch_sequencer.sv - per-core pc/fetch FSM issuing datapath opcodes
// Optional retire counter output enabled by FETCH_RETIRE_COUNT_EN.
module core_fetch_sequencer
  import core_isa_pkg::*;
#(
  parameter int CORE_ID = 0,
  parameter int PC_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic [PC_W-1:0]     addr,
  input  logic [OPCODE_W-1:0] instruction,
  input  logic                z_flag,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [OPCODE_W-1:0] issue_opcode,
  output logic                active,
`ifdef FETCH_RETIRE_COUNT_EN
  output logic [15:0]         retired_count,
`endif
  output logic                halted
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            jump_pending;
  opclass_e        op_class;

  core_opcode_classify #(.CORE_ID(CORE_ID)) u_classify (
    .instr    (instruction),
    .op_class (op_class)
  );

  assign addr    = pc;
  assign pc_next = pc + PC_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= '0;
      active       <= 1'b1;
      halted       <= 1'b0;
      issue_valid  <= 1'b0;
      issue_opcode <= '0;
      jump_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc           <= '0;
            halted       <= 1'b0;
            active       <= 1'b1;
            jump_pending <= 1'b0;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= jump_pending ? S_OPND : S_DECODE;
        end
        S_DECODE: begin
          case (op_class)
            CLS_EN_SELF: begin
              active <= 1'b1;
              pc     <= pc_next;
              state  <= S_FETCH;
            end
            CLS_EN_OTHER: begin
              active <= 1'b0;
              pc     <= pc_next;
              state  <= S_FETCH;
            end
            CLS_END: begin
              if (active && z_flag) begin
                halted <= 1'b1;
                state  <= S_HALT;
              end else begin
                pc    <= pc_next;
                state <= S_FETCH;
              end
            end
            CLS_JUMP: begin
              // Jumps resolve even when the core is disabled so all cores stay in lockstep.
              jump_pending <= 1'b1;
              pc           <= pc_next;
              state        <= S_FETCH;
            end
            default: begin
              if (active) begin
                issue_opcode <= instruction;
                issue_valid  <= 1'b1;
                state        <= S_ISSUE;
              end else begin
                pc    <= pc_next;
                state <= S_FETCH;
              end
            end
          endcase
        end
        S_OPND: begin
          jump_pending <= 1'b0;
          pc           <= z_flag ? pc_next : PC_W'(instruction);
          state        <= S_FETCH;
        end
        S_ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            pc          <= pc_next;
            state       <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_RETIRE_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_count <= '0;
    end else if (start && (state == S_IDLE || state == S_HALT)) begin
      retired_count <= '0;
    end else if (issue_valid && issue_ready && retired_count != 16'hFFFF) begin
      retired_count <= retired_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_fetch_sequencer.sv
// tb/tb_core_fetch_sequencer.sv - scoreboard bench for core_fetch_sequencer (CORE_ID 0 and 1)
module tb_core_fetch_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] addr0, addr1, instr0, instr1, opc0, opc1;
  logic       z0 = 1'b0, z1 = 1'b1;
  logic       ready0 = 1'b1, ready1 = 1'b1;
  logic       valid0, valid1, active0, active1, halted0, halted1;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [15:0] rc0, rc1;
`endif

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int errors = 0, checks = 0, n0 = 0, n1 = 0;

  logic [7:0] exp_a [30] = '{0,0,0,1,1,1,2,2,3,3,4,4,5,5,6,6,28,28,29,29,30,30,31,31,31,31,31,31,31,31};
  logic [7:0] exp_c [10] = '{0,0,1,1,255,255,255,0,0,0};

  always #5 clock = ~clock;

  always @(posedge clock) begin
    instr0 <= mem0[addr0];
    instr1 <= mem1[addr1];
  end

  core_fetch_sequencer #(.CORE_ID(0), .PC_W(8)) u_dut0 (
    .clock(clock), .reset(reset), .start(start0), .addr(addr0), .instruction(instr0),
    .z_flag(z0), .issue_valid(valid0), .issue_ready(ready0), .issue_opcode(opc0),
    .active(active0),
`ifdef FETCH_RETIRE_COUNT_EN
    .retired_count(rc0),
`endif
    .halted(halted0));

  core_fetch_sequencer #(.CORE_ID(1), .PC_W(8)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .addr(addr1), .instruction(instr1),
    .z_flag(z1), .issue_valid(valid1), .issue_ready(ready1), .issue_opcode(opc1),
    .active(active1),
`ifdef FETCH_RETIRE_COUNT_EN
    .retired_count(rc1),
`endif
    .halted(halted1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop one expected opcode per completed handshake.
  always @(negedge clock) begin
    if (!reset && valid0 && ready0) begin
      n0++;
      if (q0.size() == 0) chk("dut0 unexpected issue", 32'(opc0), 32'hFFFF);
      else chk("dut0 issue opcode", 32'(opc0), 32'(q0.pop_front()));
    end
  end

  always @(negedge clock) begin
    if (!reset && valid1 && ready1) begin
      n1++;
      if (q1.size() == 0) chk("dut1 unexpected issue", 32'(opc1), 32'hFFFF);
      else chk("dut1 issue opcode", 32'(opc1), 32'(q1.pop_front()));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'd0;
      mem1[i] = 8'd0;
    end
    mem0[0] = 8'd9;  mem0[1] = 8'd11; mem0[2] = 8'd4; mem0[3] = 8'd9;
    mem0[4] = 8'd3;  mem0[5] = 8'd40; mem0[6] = 8'd28;
    mem0[28] = 8'd38; mem0[29] = 8'd40; mem0[30] = 8'd99; mem0[31] = 8'd38;
    mem1[0] = 8'd3; mem1[1] = 8'd9; mem1[2] = 8'd4; mem1[3] = 8'd9; mem1[4] = 8'd38;

    step();
    chk("reset addr", 32'(addr0), 0);
    chk("reset active", 32'(active0), 1);
    chk("reset halted", 32'(halted0), 0);
    chk("reset issue_valid", 32'(valid0), 0);
    chk("reset issue_opcode", 32'(opc0), 0);
    step();
    reset = 1'b0;
    step();
    step();
    chk("idle addr", 32'(addr0), 0);
    chk("idle issue_valid", 32'(valid0), 0);

    // Run A on dut0, with dut1 running its own EN program alongside.
    q0.push_back(8'd9);
    q0.push_back(8'd11);
    q1.push_back(8'd9);
    start0 = 1'b1;
    start1 = 1'b1;
    step();
    start0 = 1'b0;
    start1 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) step();
      z0 = (k >= 20);
      chk($sformatf("runA addr k%0d", k), 32'(addr0), 32'(exp_a[k]));
      if (k == 8 || k == 10) chk($sformatf("runA active k%0d", k), 32'(active0), 0);
      if (k == 12) chk("runA active after EN0", 32'(active0), 1);
      if (k == 23) chk("runA not yet halted", 32'(halted0), 0);
      if (k == 2) chk("dut1 active after EN0", 32'(active1), 0);
      if (k == 24) begin
        chk("runA halted", 32'(halted0), 1);
        chk("runA halted issue_valid", 32'(valid0), 0);
        chk("dut1 halted", 32'(halted1), 1);
        chk("dut1 addr", 32'(addr1), 4);
        chk("dut1 active", 32'(active1), 1);
`ifdef FETCH_RETIRE_COUNT_EN
        chk("runA retired_count", 32'(rc0), 2);
`endif
      end
    end

    // Run B: restart from HALT, stall in ISSUE, then reset mid-ISSUE.
    ready0 = 1'b0;
    z0 = 1'b0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("runB halted cleared", 32'(halted0), 0);
    chk("runB active", 32'(active0), 1);
    chk("runB addr k0", 32'(addr0), 0);
    step();
    chk("runB decode issue_valid", 32'(valid0), 0);
    for (int k = 2; k <= 6; k++) begin
      step();
      chk($sformatf("runB stall valid k%0d", k), 32'(valid0), 1);
      chk($sformatf("runB stall opcode k%0d", k), 32'(opc0), 9);
      chk($sformatf("runB stall addr k%0d", k), 32'(addr0), 0);
    end
    #2 reset = 1'b1;
    #1;
    chk("async reset issue_valid", 32'(valid0), 0);
    chk("async reset opcode", 32'(opc0), 0);
    chk("async reset addr", 32'(addr0), 0);
    #2 reset = 1'b0;
    ready0 = 1'b1;
    step();
    step();
    chk("post reset idle valid", 32'(valid0), 0);
    chk("post reset idle addr", 32'(addr0), 0);

    // Run C: jump to 255, issue there, pc wraps to 0, then END halts.
    mem0[0] = 8'd40; mem0[1] = 8'd255; mem0[255] = 8'd77;
    q0.push_back(8'd77);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      if (k == 4) begin
        mem0[0] = 8'd38;
        z0 = 1'b1;
      end
      chk($sformatf("runC addr k%0d", k), 32'(addr0), 32'(exp_c[k]));
    end
    chk("runC halted", 32'(halted0), 1);
`ifdef FETCH_RETIRE_COUNT_EN
    chk("runC retired_count", 32'(rc0), 1);
`endif

    step();
    chk("dut0 scoreboard drained", 32'(q0.size()), 0);
    chk("dut1 scoreboard drained", 32'(q1.size()), 0);
    chk("dut0 issue count", 32'(n0), 3);
    chk("dut1 issue count", 32'(n1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
